// File: rtl/piso_tx_sched_pkg.sv
// Shared definitions for the PISO transmit scheduler.
// Contents: FSM state encoding, gap-counter width and a helper that sizes
// the per-frame bit counter from the word width.
package piso_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int GAP_W = 4;

    // Bit counter must index 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_tx_sched_if.sv
// Requester-side handshake bundle for piso_tx_sched.
// Signals: two valid/data/ready triplets, one per requester.
//   master : word producer (drives valid/data, observes ready)
//   slave  : scheduler (observes valid/data, drives ready)
interface piso_tx_sched_if #(
    parameter int N = 8
);
    logic         req0_valid_in;
    logic [N-1:0] req0_data_in;
    logic         req0_ready_out;
    logic         req1_valid_in;
    logic [N-1:0] req1_data_in;
    logic         req1_ready_out;

    modport master (
        output req0_valid_in, req0_data_in, req1_valid_in, req1_data_in,
        input  req0_ready_out, req1_ready_out
    );

    modport slave (
        input  req0_valid_in, req0_data_in, req1_valid_in, req1_data_in,
        output req0_ready_out, req1_ready_out
    );
endinterface

// File: rtl/piso_tx_sched_core.sv
// Parallel-in/serial-out shift register datapath.
// Ports:
//   clk, reset_al_in : clock, asynchronous active-low reset (clears register)
//   load_in          : load d_in (wins over shift_in)
//   shift_in         : shift right, zero fill
//   d_in[N-1:0]      : parallel word
//   q_out            : current LSB
module piso_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         load_in,
    input  logic         shift_in,
    input  logic [N-1:0] d_in,
    output logic         q_out
);
    logic [N-1:0] sh;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            sh <= '0;
        end else if (load_in) begin
            sh <= d_in;
        end else if (shift_in) begin
            sh <= {1'b0, sh[N-1:1]};
        end
    end

    assign q_out = sh[0];
endmodule

// File: rtl/piso_tx_sched.sv
// Two-requester round-robin scheduler feeding a PISO serial link.
// Ports:
//   clk, reset_al_in : clock, asynchronous active-low reset
//   req (slave)      : requester valid/data/ready handshakes
//   stall_in         : freezes shifting and blocks acceptance
//   ser_out          : serial data, LSB first
//   frame_out        : high while ser_out carries a data bit
//   src_out          : requester owning the current/last frame
//   busy_out         : scheduler not idle
//   done_out         : one-cycle pulse after the last bit
module piso_tx_sched
    import piso_tx_sched_pkg::*;
#(
    parameter int N   = 8,
    parameter int GAP = 1
) (
    input  logic                 clk,
    input  logic                 reset_al_in,
    piso_tx_sched_if.slave       req,
    input  logic                 stall_in,
    output logic                 ser_out,
    output logic                 frame_out,
    output logic                 src_out,
    output logic                 busy_out,
    output logic                 done_out
);
    localparam int CW = cnt_width(N);

    state_t             state;
    logic [CW-1:0]      bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_grant;
    logic               src;
    logic               done;

    logic grant0, grant1, open, accept, shift_en, q;

    // With both valid, the requester that did not win last time is granted.
    always_comb begin
        grant0 = req.req0_valid_in & (~req.req1_valid_in |  last_grant);
        grant1 = req.req1_valid_in & (~req.req0_valid_in | ~last_grant);
    end

    // Reset gating keeps ready low while reset is held, independent of state.
    assign open               = reset_al_in & (state == ST_IDLE) & ~stall_in;
    assign req.req0_ready_out = open & grant0;
    assign req.req1_ready_out = open & grant1;
    assign accept             = open & (grant0 | grant1);
    assign shift_en           = (state == ST_SHIFT) & ~stall_in;

    piso_core #(.N(N)) u_core (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .load_in     (accept),
        .shift_in    (shift_en),
        .d_in        (grant1 ? req.req1_data_in : req.req0_data_in),
        .q_out       (q)
    );

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            src        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bit_cnt    <= '0;
                        src        <= grant1;
                        last_grant <= grant1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!stall_in) begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(N - 1)) begin
                            done <= 1'b1;
                            if (GAP == 0) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= GAP_W'(GAP);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign frame_out = (state == ST_SHIFT);
    assign ser_out   = frame_out & q;
    assign busy_out  = (state != ST_IDLE);
    assign src_out   = src;
    assign done_out  = done;
endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench for piso_tx_sched: instance a (N=8, GAP=1) and
// instance b (N=8, GAP=0). Accepted words are pushed bitwise into a
// per-instance queue and popped against ser_out while frame_out is high.
module tb_piso_tx_sched;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    logic         v0[2], v1[2], r0[2], r1[2], stall[2];
    logic         ser[2], frame[2], src[2], busy[2], done[2];
    logic [N-1:0] d0[2], d1[2];

    piso_tx_sched_if #(.N(N)) ifa ();
    piso_tx_sched_if #(.N(N)) ifb ();

    assign ifa.req0_valid_in = v0[0];
    assign ifa.req0_data_in  = d0[0];
    assign ifa.req1_valid_in = v1[0];
    assign ifa.req1_data_in  = d1[0];
    assign r0[0]             = ifa.req0_ready_out;
    assign r1[0]             = ifa.req1_ready_out;
    assign ifb.req0_valid_in = v0[1];
    assign ifb.req0_data_in  = d0[1];
    assign ifb.req1_valid_in = v1[1];
    assign ifb.req1_data_in  = d1[1];
    assign r0[1]             = ifb.req0_ready_out;
    assign r1[1]             = ifb.req1_ready_out;

    piso_tx_sched #(.N(N), .GAP(1)) dut_a (
        .clk(clk), .reset_al_in(rst_n), .req(ifa.slave), .stall_in(stall[0]),
        .ser_out(ser[0]), .frame_out(frame[0]), .src_out(src[0]),
        .busy_out(busy[0]), .done_out(done[0])
    );

    piso_tx_sched #(.N(N), .GAP(0)) dut_b (
        .clk(clk), .reset_al_in(rst_n), .req(ifb.slave), .stall_in(stall[1]),
        .ser_out(ser[1]), .frame_out(frame[1]), .src_out(src[1]),
        .busy_out(busy[1]), .done_out(done[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    int   acc_cyc_a[$], acc_cyc_b[$];
    logic acc_src_a[$], acc_src_b[$];
    int   flen_last[2];

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic bq[$];
        logic prev_frame = 1'b0;
        logic prev_stall = 1'b0;
        logic last_bit   = 1'b0;
        logic exp_src    = 1'b0;
        int   flen       = 0;

        always @(negedge clk) begin
            if (rst_n !== 1'b1) begin
                check_eq("rst_ready0", r0[g], 0);
                check_eq("rst_ready1", r1[g], 0);
                check_eq("rst_frame", frame[g], 0);
                check_eq("rst_ser", ser[g], 0);
                check_eq("rst_busy", busy[g], 0);
                check_eq("rst_done", done[g], 0);
                bq.delete();
                prev_frame = 1'b0;
                prev_stall = 1'b0;
                flen       = 0;
            end else begin
                check_eq("done", done[g], prev_frame && !prev_stall && bq.size() == 0);
                if (frame[g]) begin
                    check_eq("busy_in_frame", busy[g], 1);
                    if (prev_frame && prev_stall) begin
                        check_eq("ser_hold", ser[g], last_bit);
                    end else if (bq.size() == 0) begin
                        check_eq("ser_extra_bit", frame[g], 0);
                    end else begin
                        last_bit = bq.pop_front();
                        check_eq("ser_bit", ser[g], last_bit);
                    end
                    flen++;
                end else begin
                    check_eq("ser_idle", ser[g], 0);
                    if (done[g]) begin
                        check_eq("src_at_done", src[g], exp_src);
                        flen_last[g] = flen;
                        flen = 0;
                    end
                end
                check_eq("ready_exclusive", r0[g] & r1[g], 0);
                check_eq("ready0_needs_valid", r0[g] & ~v0[g], 0);
                check_eq("ready1_needs_valid", r1[g] & ~v1[g], 0);
                if (r0[g] && v0[g]) begin
                    for (int i = 0; i < N; i++) bq.push_back(d0[g][i]);
                    exp_src = 1'b0;
                    if (g == 0) begin acc_cyc_a.push_back(cyc); acc_src_a.push_back(1'b0); end
                    else        begin acc_cyc_b.push_back(cyc); acc_src_b.push_back(1'b0); end
                end
                if (r1[g] && v1[g]) begin
                    for (int i = 0; i < N; i++) bq.push_back(d1[g][i]);
                    exp_src = 1'b1;
                    if (g == 0) begin acc_cyc_a.push_back(cyc); acc_src_a.push_back(1'b1); end
                    else        begin acc_cyc_b.push_back(cyc); acc_src_b.push_back(1'b1); end
                end
            end
            prev_frame = frame[g];
            prev_stall = stall[g];
        end
    end

    // Returns at negedge+1 of the done cycle.
    task automatic wait_done(input int g);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done[g]) break;
        end
        check_eq("done_seen", done[g], 1);
        #1;
    endtask

    task automatic wait_ready(input int g, input int which);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if ((which == 0) ? r0[g] : r1[g]) break;
        end
        check_eq("ready_seen", (which == 0) ? r0[g] : r1[g], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1'b0; v1[g] = 1'b0; stall[g] = 1'b0;
            d0[g] = '0;   d1[g] = '0;
        end
        v0[0] = 1'b1;
        d0[0] = 8'h11;
        repeat (2) @(negedge clk);
        check_eq("reset_src", src[0], 0);
        check_eq("reset_ready0_forced", r0[0], 0);
        v0[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Single word from requester 0
        @(posedge clk); #1;
        v0[0] = 1'b1; d0[0] = 8'hA5;
        @(negedge clk);
        check_eq("t1_ready0_same_cycle", r0[0], 1);
        @(posedge clk); #1 v0[0] = 1'b0;
        wait_done(0);
        check_eq("t1_src", src[0], 0);
        check_eq("t1_frame_len", flen_last[0], 8);
        @(negedge clk);
        check_eq("t1_done_one_cycle", done[0], 0);

        // Stall for 3 cycles while bit 4 is on the line
        @(posedge clk); #1;
        v0[0] = 1'b1; d0[0] = 8'h5A;
        wait_ready(0, 0);
        @(posedge clk); #1 v0[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_bit4_held", ser[0], 1);
            @(posedge clk); #1;
        end
        stall[0] = 1'b0;
        @(negedge clk);
        check_eq("t3_bit4_last", ser[0], 1);
        wait_done(0);
        check_eq("t3_frame_len", flen_last[0], 11);
        check_eq("t3_src", src[0], 0);

        // Asynchronous reset during bit 3
        @(posedge clk); #1;
        v0[0] = 1'b1; d0[0] = 8'hFF;
        wait_ready(0, 0);
        @(posedge clk); #1 v0[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("t4_frame_before", frame[0], 1);
        check_eq("t4_ser_before", ser[0], 1);
        rst_n = 1'b0;
        #1;
        check_eq("t4_ser_async", ser[0], 0);
        check_eq("t4_frame_async", frame[0], 0);
        check_eq("t4_busy_async", busy[0], 0);
        v0[0] = 1'b1; d0[0] = 8'h0F;
        v1[0] = 1'b1; d1[0] = 8'hF0;
        acc_cyc_a.delete(); acc_src_a.delete();
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // Both requesters continuously valid: alternation and period
        for (int k = 0; k < 60 && acc_cyc_a.size() < 4; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        v0[0] = 1'b0; v1[0] = 1'b0;
        check_eq("t2_accepts", acc_cyc_a.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < acc_src_a.size()) check_eq("t2_grant", acc_src_a[k], k % 2);
            if (k > 0 && k < acc_cyc_a.size())
                check_eq("t2_period", acc_cyc_a[k] - acc_cyc_a[k-1], 10);
        end
        wait_done(0);
        check_eq("t2_src_last", src[0], 1);

        // Stall in IDLE blocks acceptance
        @(posedge clk); #1;
        stall[0] = 1'b1; v1[0] = 1'b1; d1[0] = 8'h3C;
        repeat (3) begin
            @(negedge clk);
            check_eq("t6_ready1_stalled", r1[0], 0);
            check_eq("t6_idle", busy[0], 0);
            @(posedge clk); #1;
        end
        stall[0] = 1'b0;
        @(negedge clk);
        check_eq("t6_ready1_after_stall", r1[0], 1);
        @(posedge clk); #1 v1[0] = 1'b0;
        wait_done(0);
        check_eq("t6_src", src[0], 1);

        // GAP=0 instance, requester 1 continuously valid
        acc_cyc_b.delete(); acc_src_b.delete();
        @(posedge clk); #1;
        v1[1] = 1'b1; d1[1] = 8'hC3;
        for (int k = 0; k < 60 && acc_cyc_b.size() < 4; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 v1[1] = 1'b0;
        check_eq("t5_accepts", acc_cyc_b.size(), 4);
        for (int k = 1; k < acc_cyc_b.size(); k++) begin
            check_eq("t5_period", acc_cyc_b[k] - acc_cyc_b[k-1], 9);
            check_eq("t5_src", acc_src_b[k], 1);
        end
        wait_done(1);
        check_eq("t5_frame_len", flen_last[1], 8);
        check_eq("t5_src_done", src[1], 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
